frame_config_writer: RTL and testbench

Fabric configuration frame writer: the driving end of the `FrameData`/`FrameStrobe` configuration interface that every tile column consumes and buffers through to its neighbour. It takes a 32-bit bitstream word stream over a valid/ready handshake, assembles one full frame (one word per tile row) and fires a single-cycle one-hot `FrameStrobe` pulse into its column. It sits between the bitstream source (UART/SPI loader) and the top tile of one fabric column.

---
 rtl/frame_cfg_pkg.sv | 37 +++
 rtl/frame_strobe_decode.sv | 45 ++++
 rtl/frame_config_writer.sv | 143 ++++++++++++++
 tb/tb_frame_config_writer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_cfg_pkg.sv
// Shared constants, header field layout and FSM state type for the
// configuration frame writer.
package frame_cfg_pkg;

    localparam logic [31:0] SYNC     = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC   = 32'hFAB0_FAB0;
    localparam logic [7:0]  HDR_MARK = 8'hA5;

    // Header word layout: [31:24] marker, [23:16] column, [4:0] frame index.
    localparam int HDR_MARK_LSB = 24;
    localparam int HDR_MARK_W   = 8;
    localparam int HDR_COL_LSB  = 16;
    localparam int HDR_COL_W    = 8;
    localparam int HDR_IDX_LSB  = 0;
    localparam int HDR_IDX_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_STROBE,
        ST_HOLD
    } state_t;

    function automatic logic [HDR_MARK_W-1:0] hdr_mark(input logic [31:0] w);
        return w[HDR_MARK_LSB +: HDR_MARK_W];
    endfunction

    function automatic logic [HDR_COL_W-1:0] hdr_col(input logic [31:0] w);
        return w[HDR_COL_LSB +: HDR_COL_W];
    endfunction

    function automatic logic [HDR_IDX_W-1:0] hdr_idx(input logic [31:0] w);
        return w[HDR_IDX_LSB +: HDR_IDX_W];
    endfunction

endpackage

// File: rtl/frame_strobe_decode.sv
// Registered frame-index to one-hot strobe decoder. Fires only when enabled
// and the latched column matches this writer's column; otherwise all-zero.
module frame_strobe_decode
    import frame_cfg_pkg::*;
#(
    parameter int          NumFrames = 20,
    parameter logic [7:0]  ColumnId  = 8'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_fire,
    input  logic [HDR_COL_W-1:0]  i_col,
    input  logic [HDR_IDX_W-1:0]  i_idx,
    output logic                  o_hit,
    output logic [NumFrames-1:0]  o_strobe
);

    logic                 w_hit;
    logic [NumFrames-1:0] w_onehot;
    logic [NumFrames-1:0] r_strobe;

    assign w_hit = i_fire && (i_col == ColumnId);
    assign o_hit = w_hit;

    // One-hot image of the frame index; the index is range-checked upstream.
    always_comb begin
        for (int i = 0; i < NumFrames; i++) begin
            w_onehot[i] = (int'(i_idx) == i);
        end
    end

    // Strobe register: one cycle of one-hot per hit, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_strobe <= '0;
        end else if (w_hit) begin
            r_strobe <= w_onehot;
        end else begin
            r_strobe <= '0;
        end
    end

    assign o_strobe = r_strobe;

endmodule

// File: rtl/frame_config_writer.sv
// Configuration frame writer: accepts a bitstream word stream, assembles one
// word per tile row and fires a single-cycle one-hot FrameStrobe per frame.
module frame_config_writer
    import frame_cfg_pkg::*;
#(
    parameter int         MaxFramesPerCol = 20,
    parameter int         FrameBitsPerRow = 32,
    parameter int         NumRows         = 16,
    parameter logic [7:0] ColumnId        = 8'd0
) (
    input  logic                                UserCLK,
    input  logic                                Reset,
    input  logic [FrameBitsPerRow-1:0]          s_data,
    input  logic                                s_valid,
    output logic                                s_ready,
    output logic [FrameBitsPerRow*NumRows-1:0]  FrameData,
    output logic [MaxFramesPerCol-1:0]          FrameStrobe,
    output logic                                synced,
    output logic                                err,
    output logic [15:0]                         frames_written
);

    localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;

    state_t                              r_state;
    state_t                              w_next_state;
    logic [RowW-1:0]                     r_row_cnt;
    logic [HDR_COL_W-1:0]                r_col;
    logic [HDR_IDX_W-1:0]                r_idx;
    logic                                r_err;
    logic [15:0]                         r_frames_written;
    logic [FrameBitsPerRow*NumRows-1:0]  r_frame_data;

    logic w_xfer;
    logic w_hdr_ok;
    logic w_last_row;
    logic w_fire;
    logic w_hit;

    assign w_xfer     = s_valid && s_ready;
    assign w_hdr_ok   = (hdr_mark(s_data) == HDR_MARK) &&
                        (int'(hdr_idx(s_data)) < MaxFramesPerCol);
    assign w_last_row = (r_row_cnt == RowW'(NumRows - 1));
    assign w_fire     = (r_state == ST_DATA) && w_xfer && w_last_row;

    // State register.
    // NOTE: every clocked process uses <= so all registers update from
    // the same pre-edge values regardless of process ordering.
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment at the top keeps this purely
    // combinational; a path that skipped it would infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && (s_data == SYNC)) w_next_state = ST_HEADER;
            end
            ST_HEADER: begin
                if (w_xfer) begin
                    if (s_data == DESYNC)  w_next_state = ST_IDLE;
                    else if (w_hdr_ok)     w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_xfer && w_last_row) w_next_state = ST_STROBE;
            end
            ST_STROBE: w_next_state = ST_HOLD;
            ST_HOLD:   w_next_state = ST_HEADER;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        s_ready = 1'b0;
        synced  = 1'b0;
        case (r_state)
            ST_IDLE:   s_ready = 1'b1;
            ST_HEADER: begin s_ready = 1'b1; synced = 1'b1; end
            ST_DATA:   begin s_ready = 1'b1; synced = 1'b1; end
            ST_STROBE: synced = 1'b1;
            ST_HOLD:   synced = 1'b1;
            default:   s_ready = 1'b0;
        endcase
    end

    // Datapath: header latch, row counter, row registers, error and count.
    // NOTE: the row registers are a plain register bank (not a RAM), so
    // they take a defined zero on reset like every other register here.
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            r_row_cnt        <= '0;
            r_col            <= '0;
            r_idx            <= '0;
            r_err            <= 1'b0;
            r_frames_written <= '0;
            r_frame_data     <= '0;
        end else begin
            if ((r_state == ST_HEADER) && w_xfer && (s_data != DESYNC)) begin
                if (w_hdr_ok) begin
                    r_col     <= hdr_col(s_data);
                    r_idx     <= hdr_idx(s_data);
                    r_row_cnt <= '0;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if ((r_state == ST_DATA) && w_xfer) begin
                r_frame_data[int'(r_row_cnt)*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                r_row_cnt <= r_row_cnt + 1'b1;
            end
            if (w_hit) begin
                r_frames_written <= r_frames_written + 16'd1;
            end
        end
    end

    frame_strobe_decode #(
        .NumFrames (MaxFramesPerCol),
        .ColumnId  (ColumnId)
    ) u_strobe (
        .clk      (UserCLK),
        .rst      (Reset),
        .i_fire   (w_fire),
        .i_col    (r_col),
        .i_idx    (r_idx),
        .o_hit    (w_hit),
        .o_strobe (FrameStrobe)
    );

    assign FrameData      = r_frame_data;
    assign err            = r_err;
    assign frames_written = r_frames_written;

endmodule

// File: tb/tb_frame_config_writer.sv
// Self-checking bench for frame_config_writer: randomized word stream checked
// against a stream-level reference interpreter.
module tb_frame_config_writer;

    localparam logic [31:0] SYNC_W   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_W = 32'hFAB0_FAB0;
    localparam int          ROWS     = 16;
    localparam int          FRAMES   = 20;

    logic          UserCLK = 1'b0;
    logic          Reset   = 1'b1;
    logic [31:0]   s_data  = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [511:0]  FrameData;
    logic [19:0]   FrameStrobe;
    logic          synced;
    logic          err;
    logic [15:0]   frames_written;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    // reference model state
    bit          m_synced;
    bit          m_err;
    bit          m_in_frame;
    int          m_row;
    logic [7:0]  m_col;
    int          m_idx;
    logic [31:0] m_rows [ROWS];
    logic [15:0] m_count;
    int          m_pulses = 0;
    bit          frame_done;
    logic [19:0] m_exp_strobe;
    bit          reset_in_strobe = 1'b0;

    always #5 UserCLK = ~UserCLK;

    frame_config_writer dut (
        .UserCLK        (UserCLK),
        .Reset          (Reset),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .FrameData      (FrameData),
        .FrameStrobe    (FrameStrobe),
        .synced         (synced),
        .err            (err),
        .frames_written (frames_written)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Any cycle with a nonzero strobe must be one-hot; count them all.
    always @(negedge UserCLK) begin
        if (FrameStrobe != '0) begin
            pulses++;
            check("strobe_onehot", 512'($onehot(FrameStrobe)), 512'd1);
        end
    end

    function automatic logic [511:0] model_frame();
        logic [511:0] f;
        for (int r = 0; r < ROWS; r++) f[r*32 +: 32] = m_rows[r];
        return f;
    endfunction

    function void model_reset();
        m_synced = 0; m_err = 0; m_in_frame = 0; m_row = 0;
        m_count = '0; frame_done = 0;
        for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
    endfunction

    // Interpret one accepted word at the stream level.
    function void model_accept(input logic [31:0] w);
        if (!m_synced) begin
            if (w == SYNC_W) m_synced = 1;
        end else if (!m_in_frame) begin
            if (w == DESYNC_W) m_synced = 0;
            else if (w[31:24] == 8'hA5 && int'(w[4:0]) < FRAMES) begin
                m_col = w[23:16]; m_idx = int'(w[4:0]);
                m_row = 0; m_in_frame = 1;
            end else m_err = 1;
        end else begin
            m_rows[m_row] = w;
            m_row++;
            if (m_row == ROWS) begin
                m_in_frame = 0;
                frame_done = 1;
                if (m_col == 8'd0) begin
                    m_exp_strobe = 20'd1 << m_idx;
                    m_count = m_count + 16'd1;
                    m_pulses++;
                end else m_exp_strobe = '0;
            end
        end
    endfunction

    task automatic do_reset();
        Reset = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (2) begin @(posedge UserCLK); #1; end
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic handle_frame();
        frame_done = 0;
        if (reset_in_strobe) begin
            Reset = 1'b1;
            @(posedge UserCLK); #1;
            Reset = 1'b0;
            model_reset();
            check("rst_strobe_fs", 512'(FrameStrobe), 512'd0);
            check("rst_strobe_fd", FrameData, 512'd0);
            check("rst_strobe_ready", 512'(s_ready), 512'd1);
            check("rst_strobe_synced", 512'(synced), 512'd0);
            check("rst_strobe_count", 512'(frames_written), 512'd0);
            check("rst_strobe_err", 512'(err), 512'd0);
            return;
        end
        check("strobe_pulse", 512'(FrameStrobe), 512'(m_exp_strobe));
        check("frame_data", FrameData, model_frame());
        check("ready_strobe", 512'(s_ready), 512'd0);
        // offer a junk word while the writer must not take it
        s_valid = 1'b1; s_data = $urandom;
        @(posedge UserCLK); #1;
        check("strobe_fall", 512'(FrameStrobe), 512'd0);
        check("ready_hold", 512'(s_ready), 512'd0);
        @(posedge UserCLK); #1;
        s_valid = 1'b0;
        check("ready_back", 512'(s_ready), 512'd1);
        check("frames_written", 512'(frames_written), 512'(m_count));
        check("frame_hold", FrameData, model_frame());
        check("synced_after", 512'(synced), 512'(m_synced));
    endtask

    task automatic send(input logic [31:0] w, input int gap_max);
        int gap;
        bit took;
        gap = $urandom_range(gap_max, 0);
        s_valid = 1'b0;
        repeat (gap) begin @(posedge UserCLK); #1; end
        s_data = w; s_valid = 1'b1;
        check("ready_before", 512'(s_ready), 512'd1);
        took = (s_ready === 1'b1);
        @(posedge UserCLK); #1;
        s_valid = 1'b0;
        if (took) model_accept(w);
        check("synced", 512'(synced), 512'(m_synced));
        check("err", 512'(err), 512'(m_err));
        if (frame_done) handle_frame();
    endtask

    task automatic send_frame(input logic [31:0] hdr, input int gap_max, input bit with_desync);
        logic [31:0] w;
        send(hdr, gap_max);
        for (int r = 0; r < ROWS; r++) begin
            w = $urandom;
            if (with_desync && r == 5) w = DESYNC_W;
            send(w, gap_max);
        end
    endtask

    function automatic logic [31:0] rand_not_sync();
        logic [31:0] w;
        w = $urandom;
        if (w == SYNC_W) w = w ^ 32'd1;
        return w;
    endfunction

    initial begin
        logic [31:0] hdr;
        logic [7:0]  col;

        // reset state
        do_reset();
        check("rst_ready", 512'(s_ready), 512'd1);
        check("rst_fd", FrameData, 512'd0);
        check("rst_fs", 512'(FrameStrobe), 512'd0);
        check("rst_synced", 512'(synced), 512'd0);
        check("rst_err", 512'(err), 512'd0);
        check("rst_count", 512'(frames_written), 512'd0);

        // words before SYNC are discarded silently
        for (int i = 0; i < 4; i++) send(rand_not_sync(), 1);
        send(32'hA500_0003, 0);
        send(DESYNC_W, 0);

        // basic frame: column 0, frame 3
        send(SYNC_W, 0);
        send(32'hA500_0003, 0);
        for (int r = 0; r < ROWS; r++) send(32'h1000_0000 + r, 0);

        // column mismatch: data loads, no strobe, count unchanged
        send_frame(32'hA501_0002, 2, 0);

        // bad headers, then repeated SYNC, then a good frame with DESYNC as data
        send(32'h1234_0000, 0);
        send(32'hA500_0014, 0);
        send(SYNC_W, 0);
        send_frame({8'hA5, 8'h00, 11'($urandom), 5'($urandom_range(FRAMES-1, 0))}, 3, 1);

        // randomized frames with backpressure gaps
        for (int f = 0; f < 6; f++) begin
            col = ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            hdr = {8'hA5, col, 11'($urandom), 5'($urandom_range(FRAMES-1, 0))};
            send_frame(hdr, 3, f[0]);
        end
        send_frame({8'hA5, 8'h00, 11'd0, 5'd19}, 0, 0);

        // DESYNC in HEADER, then header-like words are ignored
        send(DESYNC_W, 0);
        send(32'hA500_0005, 0);
        for (int i = 0; i < 3; i++) send(rand_not_sync(), 0);
        check("count_after_desync", 512'(frames_written), 512'(m_count));

        // reset landing in the STROBE cycle
        do_reset();
        send(SYNC_W, 0);
        send(32'hA500_0007, 0);
        for (int r = 0; r < ROWS - 1; r++) send($urandom, 1);
        reset_in_strobe = 1'b1;
        send($urandom, 0);
        reset_in_strobe = 1'b0;
        repeat (2) @(posedge UserCLK);
        #1;
        check("strobe_pulses", 512'(pulses), 512'(m_pulses));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
